// File: rtl/byte_serializer_pkg.sv
// Shared types and defaults for the byte serializer slice.
// No logic here: state encoding and the default word width only.
// No flow control of its own.
package byte_serializer_pkg;

   // Default parallel word width.
   localparam int DATA_W_DEF = 8;

   // Serializer FSM state encoding.
   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_e;

endpackage : byte_serializer_pkg

// File: rtl/word_hold_buf.sv
// One-entry word buffer that parks a word accepted while another is shifting.
// Latency: a write is visible on dat_o/full_o the cycle after the write edge.
// No internal backpressure: the owner gates writes with full_o.
module word_hold_buf #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         wr_i,
   input  logic [W-1:0] wr_dat_i,
   input  logic         pop_i,
   output logic [W-1:0] dat_o,
   output logic         full_o
);

   logic [W-1:0] dat_q, dat_d;
   logic         full_q, full_d;

   // Next-state: a write wins over a pop; a pop only clears the full flag.
   always_comb begin
      dat_d  = dat_q;
      full_d = full_q;
      if (wr_i) begin
         dat_d  = wr_dat_i;
         full_d = 1'b1;
      end else if (pop_i) begin
         full_d = 1'b0;
      end
   end

   // Buffer registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         dat_q  <= '0;
         full_q <= 1'b0;
      end else begin
         dat_q  <= dat_d;
         full_q <= full_d;
      end
   end

   assign dat_o  = dat_q;
   assign full_o = full_q;

endmodule : word_hold_buf

// File: rtl/byte_serializer.sv
// Parallel-to-serial converter with a one-word hold buffer for gapless back-to-back words.
// Latency: first bit on dout_bit one cycle after accept; later bits advance on bit_tick.
// Backpressure: din_ready drops only while the hold buffer is occupied (register-decoded).
module byte_serializer
   import byte_serializer_pkg::*;
#(
   parameter int DATA_W    = DATA_W_DEF,
   parameter int MSB_FIRST = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] din,
   input  logic              din_valid,
   output logic              din_ready,
   input  logic              bit_tick,
   output logic              dout_bit,
   output logic              dout_valid,
   output logic              dout_last
);

   localparam int                CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(DATA_W - 1);

   state_e              state_q, state_d;
   logic [DATA_W-1:0]   shreg_q, shreg_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;

   logic                accept;
   logic                hold_wr, hold_pop, hold_full;
   logic [DATA_W-1:0]   hold_dat;

   word_hold_buf #(.W(DATA_W)) u_hold (
      .clk      (clk),
      .reset    (reset),
      .wr_i     (hold_wr),
      .wr_dat_i (din),
      .pop_i    (hold_pop),
      .dat_o    (hold_dat),
      .full_o   (hold_full)
   );

   assign din_ready = ~hold_full;
   assign accept    = din_valid & din_ready;

   // Next-state: load from IDLE, shift on tick, and at end of word prefer the
   // held word, then a same-cycle accept, so consecutive words leave no gap bit.
   always_comb begin
      state_d  = state_q;
      shreg_d  = shreg_q;
      cnt_d    = cnt_q;
      hold_wr  = 1'b0;
      hold_pop = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               shreg_d = din;
               cnt_d   = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (bit_tick && (cnt_q == LAST_CNT)) begin
               cnt_d = '0;
               if (hold_full) begin
                  shreg_d  = hold_dat;
                  hold_pop = 1'b1;
               end else if (accept) begin
                  shreg_d = din;
               end else begin
                  shreg_d = '0;
                  state_d = IDLE;
               end
            end else begin
               if (bit_tick) begin
                  shreg_d = (MSB_FIRST != 0) ? (shreg_q << 1) : (shreg_q >> 1);
                  cnt_d   = cnt_q + CNT_W'(1);
               end
               // hold_full implies no accept, so this never overwrites a held word.
               if (accept) begin
                  hold_wr = 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, shift register and bit counter with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         shreg_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
      end
   end

   assign dout_valid = (state_q == SHIFT);
   assign dout_last  = dout_valid && (cnt_q == LAST_CNT);
   assign dout_bit   = dout_valid &
                       ((MSB_FIRST != 0) ? shreg_q[DATA_W-1] : shreg_q[0]);

endmodule : byte_serializer

// File: tb/tb_byte_serializer.sv
module tb_byte_serializer;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] din;
   logic       din_valid;
   logic       bit_tick;

   logic m_rdy, m_bit, m_vld, m_last;
   logic l_rdy, l_bit, l_vld, l_last;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   byte_serializer #(.DATA_W(8), .MSB_FIRST(1)) dut_m (
      .clk        (clk),
      .reset      (reset),
      .din        (din),
      .din_valid  (din_valid),
      .din_ready  (m_rdy),
      .bit_tick   (bit_tick),
      .dout_bit   (m_bit),
      .dout_valid (m_vld),
      .dout_last  (m_last)
   );

   byte_serializer #(.DATA_W(8), .MSB_FIRST(0)) dut_l (
      .clk        (clk),
      .reset      (reset),
      .din        (din),
      .din_valid  (din_valid),
      .din_ready  (l_rdy),
      .bit_tick   (bit_tick),
      .dout_bit   (l_bit),
      .dout_valid (l_vld),
      .dout_last  (l_last)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance to 1 time unit after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [7:0]  exp_m, exp_l;
      logic [15:0] exp_m16, exp_l16;
      int          vcnt;

      reset = 1'b1; din = '0; din_valid = 1'b0; bit_tick = 1'b0;
      step();
      step();
      // Reset values
      chk("rst_m_vld", m_vld, 0);  chk("rst_m_bit", m_bit, 0);
      chk("rst_m_last", m_last, 0); chk("rst_m_rdy", m_rdy, 1);
      chk("rst_l_vld", l_vld, 0);  chk("rst_l_rdy", l_rdy, 1);
      reset = 1'b0;
      step();
      chk("post_rst_vld", m_vld, 0);

      // Single word 0xA5: MSB stream 1010_0101, LSB stream 1010_0101
      exp_m = 8'hA5; exp_l = 8'hA5;
      din = 8'hA5; din_valid = 1'b1; bit_tick = 1'b1;
      step();
      din_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         chk("a5_m_bit", m_bit, exp_m[7-i]);
         chk("a5_l_bit", l_bit, exp_l[7-i]);
         chk("a5_vld", m_vld, 1);
         chk("a5_last", m_last, (i == 7) ? 1 : 0);
         step();
      end
      chk("a5_idle_m", m_vld, 0);
      chk("a5_idle_l", l_vld, 0);
      chk("a5_idle_bit", m_bit, 0);

      // Single word 0x0F: MSB stream 0000_1111, LSB stream 1111_0000
      exp_m = 8'h0F; exp_l = 8'hF0;
      din = 8'h0F; din_valid = 1'b1;
      step();
      din_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         chk("0f_m_bit", m_bit, exp_m[7-i]);
         chk("0f_l_bit", l_bit, exp_l[7-i]);
         chk("0f_l_last", l_last, (i == 7) ? 1 : 0);
         step();
      end
      chk("0f_idle", l_vld, 0);

      // Back-to-back 0xF0 then 0x0A: MSB F0,0A ; LSB 0F,50
      exp_m16 = 16'hF00A; exp_l16 = 16'h0F50;
      din = 8'hF0; din_valid = 1'b1;
      step();
      din = 8'h0A;
      for (int i = 0; i < 16; i++) begin
         chk("b2b_m_bit", m_bit, exp_m16[15-i]);
         chk("b2b_l_bit", l_bit, exp_l16[15-i]);
         chk("b2b_vld", m_vld, 1);
         chk("b2b_last", m_last, (i == 7 || i == 15) ? 1 : 0);
         chk("b2b_rdy", m_rdy, (i >= 1 && i <= 7) ? 0 : 1);
         if (i == 0) begin
            step();
            din_valid = 1'b0;
         end else begin
            step();
         end
      end
      chk("b2b_idle", m_vld, 0);

      // Tick every 3rd cycle, 0x81: each bit held 3 cycles
      exp_m = 8'h81;
      din = 8'h81; din_valid = 1'b1; bit_tick = 1'b0;
      step();
      din_valid = 1'b0;
      vcnt = 0;
      for (int k = 1; k <= 24; k++) begin
         if (m_vld) vcnt++;
         chk("t3_m_bit", m_bit, exp_m[7-((k-1)/3)]);
         chk("t3_l_bit", l_bit, exp_m[7-((k-1)/3)]);
         chk("t3_last", m_last, (k >= 22) ? 1 : 0);
         bit_tick = (k % 3 == 0) ? 1'b1 : 1'b0;
         step();
      end
      bit_tick = 1'b0;
      chk("t3_valid_cycles", vcnt, 24);
      chk("t3_idle", m_vld, 0);

      // Reset mid-word of 0xFF while 0x55 is held
      bit_tick = 1'b1;
      din = 8'hFF; din_valid = 1'b1;
      step();
      din = 8'h55;
      step();
      din_valid = 1'b0;
      step();
      step();
      chk("rmid_bit4", m_bit, 1);
      chk("rmid_held_rdy", m_rdy, 0);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("rmid_vld", m_vld, 0);
      chk("rmid_rdy", m_rdy, 1);
      chk("rmid_l_vld", l_vld, 0);
      vcnt = 0;
      for (int k = 0; k < 20; k++) begin
         if (m_vld || l_vld) vcnt++;
         step();
      end
      chk("rmid_no_emit", vcnt, 0);

      // Accept on the last-bit tick with empty hold: 0xC3 then 0x96
      // 0x96 MSB stream 1001_0110, LSB stream 0110_1001
      exp_m = 8'h96; exp_l = 8'h69;
      din = 8'hC3; din_valid = 1'b1;
      step();
      din_valid = 1'b0;
      for (int i = 0; i < 7; i++) step();
      chk("edge_last", m_last, 1);
      chk("edge_rdy", m_rdy, 1);
      din = 8'h96; din_valid = 1'b1;
      step();
      din_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         chk("edge_vld", m_vld, 1);
         chk("edge_m_bit", m_bit, exp_m[7-i]);
         chk("edge_l_bit", l_bit, exp_l[7-i]);
         chk("edge_rdy2", m_rdy, 1);
         chk("edge_last2", m_last, (i == 7) ? 1 : 0);
         step();
      end
      chk("edge_idle", m_vld, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_byte_serializer

// File: doc/byte_serializer.md
BYTE_SERIALIZER -- requirements
Module: byte_serializer

Interface
REQ-001 SHALL have parameter DATA_W, default 8: width of the parallel input word, in bits.
REQ-002 SHALL have parameter MSB_FIRST, default 1: 1 = transmit the MSB first, 0 = transmit the LSB first.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port din, input, DATA_W bits: parallel word to serialize.
REQ-006 SHALL have port din_valid, input, 1 bit: din holds a word offered for transfer.
REQ-007 SHALL have port din_ready, output, 1 bit: the block can accept a word this cycle.
REQ-008 SHALL have port bit_tick, input, 1 bit: bit-rate enable; the serial output advances only on cycles where bit_tick=1.
REQ-009 SHALL have port dout_bit, output, 1 bit: serial data bit, feeding the downstream serial sequence detector.
REQ-010 SHALL have port dout_valid, output, 1 bit: dout_bit carries a word bit.
REQ-011 SHALL have port dout_last, output, 1 bit: dout_bit is the final bit of the current word.

Function
REQ-012 SHALL define accept as din_valid=1 and din_ready=1 at a rising clk edge.
REQ-013 SHALL drive din_ready = NOT hold_full, decoded from registers only (no combinational path from din_valid).
REQ-014 SHALL implement an FSM with two states:
- IDLE: no word shifting.
- SHIFT: a word is being transmitted.
REQ-015 IDLE, on accept: SHALL load din into the shift register, set bit_cnt=0 and move to SHIFT; the hold buffer stays empty.
REQ-016 SHALL make the first bit visible on dout_bit in the cycle after the accepting edge (latency 1), regardless of bit_tick.
REQ-017 SHIFT, bit_tick=1 and bit_cnt<DATA_W-1: SHALL shift by one position toward the output end and set bit_cnt+1.
REQ-018 SHIFT, bit_tick=1 and bit_cnt=DATA_W-1 (end of word): SHALL resolve the next action in this priority order, staying in SHIFT with bit_cnt=0 where a word is loaded:
- hold_full: load the hold buffer into the shift register and clear hold_full.
- else, accept in the same cycle: load din directly, leaving no gap bit.
- else: move to IDLE.
REQ-019 SHIFT, on accept not consumed by REQ-018: SHALL write din to the hold buffer and set hold_full.
REQ-020 SHIFT, bit_tick=0: SHALL hold the shift register, bit_cnt and dout_bit unchanged.
REQ-021 SHALL drive dout_bit from the shift-register MSB when MSB_FIRST=1, otherwise from its LSB.
REQ-022 SHALL drive dout_valid = (state==SHIFT).
REQ-023 SHALL drive dout_last = (state==SHIFT AND bit_cnt==DATA_W-1).
REQ-024 SHALL drive dout_bit = 0 in IDLE.
REQ-025 SHALL size bit_cnt as clog2(DATA_W) bits; bit_cnt SHALL never exceed DATA_W-1 and SHALL wrap only via reload.
REQ-026 SHALL ignore din_valid whenever din_ready=0; din SHALL be sampled only on accept.

Reset
REQ-027 While reset=1 at a clock edge: state=IDLE, shift register=0, bit_cnt=0, hold buffer=0, hold_full=0.
REQ-028 SHALL drive these output values during and after reset: dout_bit=0, dout_valid=0, dout_last=0, din_ready=1.
REQ-029 A reset asserted mid-word SHALL discard both the shifting word and the held word; nothing SHALL be emitted after reset until a new accept.
REQ-030 reset SHALL take priority over accept and bit_tick in the same cycle.

Structure
REQ-031 SHALL place the FSM state encodings (IDLE=1'b0, SHIFT=1'b1) and the DATA_W default in the shared package.
REQ-032 SHALL implement the one-entry hold buffer (data, hold_full, write, pop) as the sub-module word_hold_buf.
REQ-033 SHALL keep the bit_tick generator outside this block.

Verification
REQ-034 MSB_FIRST=1, bit_tick=1 constant, din=8'hA5 accepted once:
- dout_bit = 1,0,1,0,0,1,0,1 on cycles 1..8 after accept.
- dout_last=1 only on cycle 8.
- IDLE on cycle 9.
REQ-035 MSB_FIRST=0, din=8'hA5: dout_bit = 1,0,1,0,0,1,0,1 (LSB first; 0xA5 is palindromic).
- Repeat with din=8'h0F -> 1,1,1,1,0,0,0,0.
REQ-036 Back-to-back 8'hF0 then 8'h0A with din_valid held, bit_tick=1:
- 16 contiguous valid bits with no gap.
- din_ready=0 while the hold buffer is full.
- dout_last on bits 8 and 16.
REQ-037 bit_tick=1 every 3rd cycle, din=8'h81:
- Each bit held exactly 3 cycles; the word spans 24 cycles.
- Total valid time is 24 cycles.
REQ-038 reset asserted after bit 4 of 8'hFF while 8'h55 is held:
- Next cycle: dout_valid=0, din_ready=1.
- No bits of 8'h55 are ever emitted.
REQ-039 Accept exactly on the last-bit tick with the hold buffer empty: the new word's first bit SHALL appear on the next cycle.
